// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, frame length and default timing for the PS/2 device transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUS_WAIT = 3'd1,
    ST_BIT_HIGH = 3'd2,
    ST_BIT_LOW  = 3'd3,
    ST_DONE     = 3'd4
  } ps2_state_e;

  localparam int FRAME_BITS     = 11;
  localparam int CLK_HALF_DEF   = 2000;
  localparam int IDLE_CYC_DEF   = 2500;
  localparam int FIFO_DEPTH_DEF = 4;

  // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// rtl/ps2_device_tx_if.sv - byte stream handshake plus open-drain PS/2 line bundle
interface ps2_device_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       tx_done;
  logic       tx_abort;
  logic       busy;
  logic       host_rts;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_abort, busy, host_rts
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_abort, busy, host_rts
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter: queues bytes and clocks 11-bit frames onto the open-drain bus
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = CLK_HALF_DEF,
  parameter int IDLE_CYC   = IDLE_CYC_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  output logic       TX_DONE,
  output logic       TX_ABORT,
  output logic       BUSY,
  output logic       HOST_RTS
);

  localparam int CNT_MAX = (CLK_HALF > IDLE_CYC) ? CLK_HALF : IDLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

  ps2_state_e r_state;
  ps2_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_bit;
  logic [3:0]       w_bit_nxt;

  logic r_clk_meta, r_clk_sync;
  logic r_dat_meta, r_dat_sync;
  logic r_tx_done, r_tx_abort;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_head;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_drive_dat;

  // Raw lines are asynchronous to CLOCK_50; idle bus level is high.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= PS2_CLK_IN;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= PS2_DAT_IN;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_push = TX_VALID && !w_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .i_wr_en   (w_push),
    .i_wr_data (TX_DATA),
    .o_full    (w_full),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_empty   (w_empty)
  );

  // The head stays put until DONE pops it, so an aborted frame resends the same byte.
  assign w_frame = ps2_frame(w_head);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_done  <= 1'b0;
      r_tx_abort <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_tx_done  <= w_done;
      r_tx_abort <= w_abort;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_empty) begin
          w_state_nxt = ST_BUS_WAIT;
        end
      end
      ST_BUS_WAIT: begin
        // Any low cycle on either line, including host RTS, restarts the idle count.
        if (r_clk_sync && r_dat_sync) begin
          if (r_cnt == IDLE_LAST) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_BIT_HIGH;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_BIT_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_clk_sync) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_BUS_WAIT;
          end else begin
            w_state_nxt = ST_BIT_LOW;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_BIT_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_bit_nxt   = r_bit + 4'd1;
            w_state_nxt = ST_BIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_pop       = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_drive_dat = (r_state == ST_BIT_HIGH) || (r_state == ST_BIT_LOW);

  // RESET_N gates the drivers directly so the bus is released the instant reset asserts.
  assign PS2_CLK_OE = RESET_N && (r_state == ST_BIT_LOW);
  assign PS2_DAT_OE = RESET_N && w_drive_dat && !w_frame[r_bit];
  assign TX_READY   = !w_full;
  assign TX_DONE    = r_tx_done;
  assign TX_ABORT   = r_tx_abort;
  assign BUSY       = (r_state != ST_IDLE);
  assign HOST_RTS   = r_clk_sync && !r_dat_sync;

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 The module SHALL have parameter CLK_HALF, default 2000: CLOCK_50 cycles per PS/2 clock half-period (12.5 kHz).
REQ-002 The module SHALL have parameter IDLE_CYC, default 2500: consecutive bus-idle cycles required before a frame starts (50 us).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4: transmit byte queue depth, power of two.
REQ-004 The module SHALL have port CLOCK_50, input, 1 bit: the single system clock.
REQ-005 The module SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port TX_DATA, input, 8 bits: byte to queue.
REQ-007 The module SHALL have port TX_VALID, input, 1 bit: TX_DATA is valid.
REQ-008 The module SHALL have port TX_READY, output, 1 bit: the FIFO is not full.
REQ-009 The module SHALL have port PS2_CLK_IN, input, 1 bit: raw PS/2 clock line.
REQ-010 The module SHALL have port PS2_DAT_IN, input, 1 bit: raw PS/2 data line.
REQ-011 The module SHALL have port PS2_CLK_OE, output, 1 bit: 1 pulls the clock line low (open drain).
REQ-012 The module SHALL have port PS2_DAT_OE, output, 1 bit: 1 pulls the data line low (open drain).
REQ-013 The module SHALL have port TX_DONE, output, 1 bit: one-cycle pulse when a frame completes.
REQ-014 The module SHALL have port TX_ABORT, output, 1 bit: one-cycle pulse when the host inhibits a frame.
REQ-015 The module SHALL have port BUSY, output, 1 bit: the state is not IDLE.
REQ-016 The module SHALL have port HOST_RTS, output, 1 bit: synchronized clock high and data low (host request-to-send).

Function
REQ-017 The module SHALL pass PS2_CLK_IN and PS2_DAT_IN through 2-flop synchronizers before any use.
REQ-018 The module SHALL accept a byte on a cycle where TX_VALID and TX_READY are both 1; a simultaneous push and pop SHALL be legal.
REQ-019 The module SHALL send each frame as 11 bits: start 0, data bits LSB first, odd parity (~^data), stop 1.
REQ-020 The module SHALL use states IDLE, BUS_WAIT, BIT_HIGH, BIT_LOW and DONE.
REQ-021 IDLE SHALL go to BUS_WAIT when the FIFO is not empty.
REQ-022 BUS_WAIT SHALL count consecutive cycles with both synchronized lines high, reset the count on any low cycle, and go to BIT_HIGH with bit index 0 once the count reaches IDLE_CYC.
REQ-023 In BIT_HIGH, PS2_CLK_OE SHALL be 0 and PS2_DAT_OE SHALL equal the inverse of the current bit, held for CLK_HALF cycles.
REQ-024 At the last cycle of BIT_HIGH, a synchronized clock of 0 SHALL mean host inhibit: the module SHALL release both lines, pulse TX_ABORT, keep the byte at the FIFO head, and return to BUS_WAIT with the count at 0.
REQ-025 Otherwise BIT_HIGH SHALL go to BIT_LOW.
REQ-026 BIT_LOW SHALL drive PS2_CLK_OE=1 for CLK_HALF cycles with data unchanged, then go to BIT_HIGH with index+1, or to DONE after index 10.
REQ-027 DONE SHALL release both lines for CLK_HALF cycles, then pop the FIFO, pulse TX_DONE, and go to IDLE.
REQ-028 The inhibit check SHALL apply to all 11 bits, including the stop bit.
REQ-029 When the FIFO is empty in IDLE, no line SHALL be driven.
REQ-030 HOST_RTS SHALL be informational only: it SHALL NOT start reception, and it SHALL hold off transmission through the REQ-022 count.

Reset
REQ-031 While RESET_N=0, PS2_CLK_OE and PS2_DAT_OE SHALL be 0 immediately (asynchronously).
REQ-032 While RESET_N=0, the FIFO SHALL be empty, TX_READY=1, the state SHALL be IDLE, TX_DONE/TX_ABORT/BUSY=0, and counters SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame and all queued bytes.

Structure
REQ-034 Package ps2_pkg SHALL hold the state enum, the frame length constant 11, and the default timing constants.
REQ-035 The FIFO SHALL be one sub-module, sync_fifo (parameterized width/depth, first-word-fall-through, full/empty flags).

Verification (CLK_HALF=4, IDLE_CYC=10)
REQ-036 The bench SHALL push 0x1C on an idle bus and check the DAT_OE-inverted bit sequence 0,0,0,1,1,1,0,0,0,0,1 sampled at each CLK_OE rise, the first CLK_OE rise 10+4 cycles after entering BUS_WAIT, and one TX_DONE.
REQ-037 The bench SHALL push 0xFF and check parity bit 1 and the frame duration of 11*8+4 cycles after the idle count.
REQ-038 The bench SHALL hold PS2_CLK_IN low externally during bit 3 BIT_HIGH and check a TX_ABORT pulse and both OE=0; after release and 10 idle cycles, the same byte SHALL be resent completely and TX_DONE SHALL pulse once.
REQ-039 The bench SHALL push 5 bytes back-to-back and check that TX_READY drops after 4 accepted, rises after the first TX_DONE, and all 5 bytes are sent in order.
REQ-040 The bench SHALL hold PS2_DAT_IN low while idle with a byte queued and check HOST_RTS=1 with no clock activity; on release, the frame SHALL start after 10 idle cycles.
REQ-041 The bench SHALL assert RESET_N low mid-frame during BIT_LOW and check OE=0 in the same cycle, TX_READY=1, BUSY=0, and no TX_DONE.
